// File: rtl/controle_multiplicador_5_bits.sv
// Shift-add controller for an unsigned LARGURA x LARGURA multiplier that shares
// one external adder. Each CALC cycle adds M into A (when Q[0]=1) and shifts {c,s,Q} right.
module controle_multiplicador_5_bits #(
   parameter int LARGURA = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [LARGURA-1:0]     multiplicando,
   input  logic [LARGURA-1:0]     multiplicador,
   output logic                   busy,
   output logic                   done,
   output logic [2*LARGURA-1:0]   produto,
   output logic [LARGURA-1:0]     add_a,
   output logic [LARGURA-1:0]     add_b,
   output logic                   add_cin,
   input  logic [LARGURA-1:0]     add_sum,
   input  logic                   add_cout
);

   localparam int CW = $clog2(LARGURA + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIM
   } state_t;

   state_t                 state_q, state_d;
   logic [LARGURA-1:0]     m_q, m_d;
   logic [LARGURA-1:0]     a_q, a_d;
   logic [LARGURA-1:0]     q_q, q_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2*LARGURA-1:0]   produto_q, produto_d;

   // NOTE: every variable gets a hold default before the case so no path leaves
   // one unassigned -- that is what keeps this block from inferring latches.
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      a_d       = a_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      produto_d = produto_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = multiplicando;
               q_d     = multiplicador;
               a_d     = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            a_d   = {add_cout, add_sum[LARGURA-1:1]};
            q_d   = {add_sum[0], q_q[LARGURA-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(LARGURA - 1)) begin
               // Final iteration: capture the product as it lands in {A,Q}.
               produto_d = {a_d, q_d};
               state_d   = FIM;
            end
         end
         FIM: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         m_q       <= '0;
         a_q       <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         produto_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         a_q       <= a_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         produto_q <= produto_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == FIM);
   assign produto = produto_q;
   assign add_a   = a_q;
   assign add_b   = (state_q == CALC && q_q[0]) ? m_q : '0;
   assign add_cin = 1'b0;

endmodule

// File: tb/tb_controle_multiplicador_5_bits.sv
// Self-checking bench: behavioural adder, table vectors, random operands checked
// against plain multiplication, and hand-written reset/ignore/back-to-back sequences.
module tb_controle_multiplicador_5_bits;

   localparam int W = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   multiplicando = '0;
   logic [W-1:0]   multiplicador = '0;
   logic           busy, done, add_cin, add_cout;
   logic [2*W-1:0] produto;
   logic [W-1:0]   add_a, add_b, add_sum;
   logic [W:0]     sum_full;

   int n_tests = 0;
   int n_fail  = 0;

   controle_multiplicador_5_bits #(.LARGURA(W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .multiplicando(multiplicando), .multiplicador(multiplicador),
      .busy(busy), .done(done), .produto(produto),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   // External shared adder.
   assign sum_full = {1'b0, add_a} + {1'b0, add_b} + {5'd0, add_cin};
   assign add_sum  = sum_full[W-1:0];
   assign add_cout = sum_full[W];

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   m;
      logic [W-1:0]   q;
      logic [2*W-1:0] p;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One multiplication observed over the 7 cycles after acceptance.
   // poke=1 pulses start with 7x7 once in CALC and once in FIM.
   task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [2*W-1:0] exp, input bit poke, input string name);
      int done_at = 0, done_cnt = 0, busy_cnt = 0;
      bit cout_seen = 0, addb_nz = 0, cin_nz = 0;
      logic [2*W-1:0] p_at_done = '0;
      @(negedge clk);
      start = 1'b1; multiplicando = m; multiplicador = q;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         start = 1'b0;
         multiplicando = W'($urandom); multiplicador = W'($urandom);
         if (poke && (i == 2 || i == 6)) begin
            start = 1'b1; multiplicando = 5'd7; multiplicador = 5'd7;
         end
         if (busy) busy_cnt++;
         if (done) begin done_cnt++; done_at = i; p_at_done = produto; end
         if (busy && !done && add_cout) cout_seen = 1;
         if (busy && !done && add_b != '0) addb_nz = 1;
         if (add_cin) cin_nz = 1;
      end
      start = 1'b0;
      check({name, " latency"}, done_at, 6);
      check({name, " done_width"}, done_cnt, 1);
      check({name, " busy_cycles"}, busy_cnt, 6);
      check({name, " produto"}, p_at_done, exp);
      check({name, " idle_after"}, {busy, done}, 0);
      check({name, " produto_held"}, produto, exp);
      check({name, " cin_zero"}, cin_nz, 0);
      if (q == '0) check({name, " addb_zero"}, addb_nz, 0);
      if (m == 5'd31 && q == 5'd31) check({name, " cout_captured"}, cout_seen, 1);
   endtask

   initial begin
      tbl[0] = '{5'd5,  5'd3,  10'd15};
      tbl[1] = '{5'd31, 5'd31, 10'd961};
      tbl[2] = '{5'd0,  5'd27, 10'd0};
      tbl[3] = '{5'd19, 5'd0,  10'd0};
      tbl[4] = '{5'd9,  5'd4,  10'd36};

      // Reset state.
      #12;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset produto", produto, 0);
      check("reset add_a", add_a, 0);
      check("reset add_b", add_b, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++)
         run_op(tbl[i].m, tbl[i].q, tbl[i].p, 1'b0, $sformatf("vec%0d", i));

      // Starts in CALC/FIM are ignored; the first product survives.
      run_op(5'd9, 5'd4, 10'd36, 1'b1, "ignore");
      run_op(5'd7, 5'd7, 10'd49, 1'b0, "after_ignore");

      // Reset two cycles into CALC aborts the operation.
      begin
         int late_done = 0;
         @(negedge clk);
         start = 1'b1; multiplicando = 5'd12; multiplicador = 5'd10;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         rst = 1'b1;
         #1;
         check("abort busy", busy, 0);
         check("abort done", done, 0);
         check("abort produto", produto, 0);
         @(negedge clk);
         rst = 1'b0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) late_done++;
         end
         check("abort no_done", late_done, 0);
      end
      run_op(5'd12, 5'd10, 10'd120, 1'b0, "after_abort");

      // Random operands against plain multiplication.
      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] m, q;
         m = W'($urandom_range(0, 31));
         q = W'($urandom_range(0, 31));
         run_op(m, q, 10'(m * q), 1'b0, $sformatf("rand%0d(%0dx%0d)", i, m, q));
      end

      // Back-to-back with start held high.
      begin
         logic [W-1:0]   ms[3] = '{5'd1, 5'd31, 5'd1};
         logic [W-1:0]   qs[3] = '{5'd1, 5'd1, 5'd31};
         int             at[3];
         logic [2*W-1:0] ps[3];
         int             k = 0;
         @(negedge clk);
         start = 1'b1; multiplicando = ms[0]; multiplicador = qs[0];
         for (int c = 0; c < 40 && k < 3; c++) begin
            @(negedge clk);
            if (done) begin
               at[k] = c; ps[k] = produto; k++;
               if (k < 3) begin multiplicando = ms[k]; multiplicador = qs[k]; end
            end
         end
         start = 1'b0;
         check("b2b pulses", k, 3);
         if (k == 3) begin
            check("b2b spacing1", at[1] - at[0], 7);
            check("b2b spacing2", at[2] - at[1], 7);
            check("b2b p0", ps[0], 1);
            check("b2b p1", ps[1], 31);
            check("b2b p2", ps[2], 31);
         end
         repeat (8) @(negedge clk);
         check("b2b idle", busy, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/controle_multiplicador_5_bits.md
Name: controle_multiplicador_5_bits

Overview:
- Sequential controller for an unsigned 5x5 shift-add multiplier.
- Does all additions through one external 5-bit adder/subtractor: drives its operands and carry-in, and reads its sum and carry-out in the same cycle.
- Sits between a start/operand requester and that shared adder. Produces a 10-bit product after a fixed number of cycles.

Parameters:
- LARGURA, 5, operand width in bits. Product is 2*LARGURA bits. The iteration counter is sized to hold LARGURA.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a multiplication; sampled only in IDLE.
- multiplicando  input  LARGURA  multiplicand M; captured when start is accepted.
- multiplicador  input  LARGURA  multiplier Q; captured when start is accepted.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; produto is valid.
- produto  output  2*LARGURA  result {A,Q}; held until the next accepted start.
- add_a  output  LARGURA  adder operand a; equals accumulator A.
- add_b  output  LARGURA  adder operand b; equals M when Q[0]=1, else 0.
- add_cin  output  1  adder carry-in; constant 0.
- add_sum  input  LARGURA  adder sum; combinational response to add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out.

Behaviour:
- Registers: M, A, Q (LARGURA each), cnt, state.
- States: IDLE, CALC, FIM.
- Reset (async, immediate): state=IDLE; M=A=Q=0; cnt=0; busy=0; done=0; produto=0. Reset mid-CALC aborts the operation with no done pulse.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: M<=multiplicando, Q<=multiplicador, A<=0, cnt<=0, state<=CALC.
  - Otherwise hold; produto keeps its last value.
- CALC: one iteration per clock, LARGURA iterations total.
  - Combinational: add_a=A; add_b = Q[0] ? M : 0; add_cin=0.
  - At the edge, with c=add_cout and s=add_sum: A <= {c, s[LARGURA-1:1]}; Q <= {s[0], Q[LARGURA-1:1]}; cnt <= cnt+1.
  - This is {c,s,Q} shifted right by 1. When Q[0]=0, add_b=0 and c is 0 for a correct adder.
  - When cnt reaches LARGURA-1 at an edge, that edge performs the final iteration and sets state<=FIM.
- FIM:
  - done=1 and busy=1 for exactly one cycle.
  - produto={A,Q}, registered at the transition into FIM.
  - Next edge: state<=IDLE.
- Latency: start accepted at edge k. Iterations occur at edges k+1..k+LARGURA. done is high in the cycle following edge k+LARGURA (6 cycles after acceptance for LARGURA=5). The earliest next accept is edge k+LARGURA+2.
- start while busy (CALC or FIM) is ignored, not queued. Operand inputs are don't-care outside the accepting edge.
- Outside CALC: add_b=0, add_a=A, add_cin=0. The adder result is ignored.
- Arithmetic is unsigned only; the product cannot overflow 2*LARGURA bits.
- Outputs are registered or driven by state only, except add_b, which is a mux of registered Q[0] and M.

Test Plan:
- Reset, then start with multiplicando=5, multiplicador=3 -> busy high for 6 cycles; done pulses exactly 1 cycle, 6 cycles after acceptance; produto=15.
- multiplicando=31, multiplicador=31 -> produto=961. add_cout=1 must be captured into A in at least one iteration.
- multiplicando=0, multiplicador=27, then multiplicando=19, multiplicador=0 -> produto=0 both times. For multiplicador=0, add_b=0 in every CALC cycle.
- Pulse start again in CALC and in FIM with operands 7x7 -> ignored; produto from the first op (e.g. 9x4=36) is unchanged. A start in IDLE the next cycle then yields 49.
- Assert rst two cycles into CALC of 12x10 -> busy=0, done=0, produto=0 immediately; no done pulse afterwards. A new 12x10 then yields 120.
- Back-to-back ops 1x1, 31x1, 1x31 with start held high continuously -> three done pulses, each 7 cycles apart; results 1, 31, 31.
